uart_fifo_bridge: RTL

//  Second-generation UART bridge: parametrised TX/RX FIFOs around an integrated 8N1 UART

---
 rtl/uart_fifo_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge
//   CPU-side bridge around an 8N1 UART engine. Bytes written by the CPU are
//   queued in a TX FIFO and serialised on TX when the peer grants CTS_N.
//   Bytes received on RX are queued in an RX FIFO. The CPU reads each byte
//   together with a status word. RTS_N throttles the peer when the RX FIFO
//   is nearly full. Overflow and framing errors are sticky until cleared,
//   and irq flags pending data or errors.
//
// Ports
//   CLK      system clock, all logic on posedge
//   RST_N    asynchronous active-low reset
//   dataIn   byte pushed into the TX FIFO when write is high
//   write    push dataIn (dropped silently when the TX FIFO is full)
//   read     pop the RX FIFO head into dataOut[7:0] (ignored when empty)
//   clear    clear the sticky flags frame_err / rx_ovf
//   dataOut  {3'b0, tx_busy, frame_err, rx_ovf, rx_empty, tx_full, rx_byte}
//   RX       serial input, idle high
//   TX       serial output, idle high
//   CTS_N    low = peer may accept data
//   RTS_N    low = we may accept data
//   irq      ~rx_empty | frame_err | rx_ovf, registered
// ---------------------------------------------------------------------------
module uart_fifo_bridge #(
  parameter int BAUD_DIV   = 104,
  parameter int TX_AW      = 4,
  parameter int RX_AW      = 4,
  parameter int RTS_MARGIN = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  dataIn,
  input  logic        write,
  input  logic        read,
  input  logic        clear,
  output logic [15:0] dataOut,
  input  logic        RX,
  output logic        TX,
  input  logic        CTS_N,
  output logic        RTS_N,
  output logic        irq
);

  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int RX_PW    = RX_AW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- sync
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic cts_meta_q, cts_sync_q;

  // Two-flop synchronisers; rx_prev_q supports falling-edge detection.
  // CTS resets to "not granted" so nothing is sent before the peer is seen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      cts_meta_q <= CTS_N;
      cts_sync_q <= cts_meta_q;
    end
  end

  // ------------------------------------------------------------- TX FIFO
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TX_AW:0] tx_wr_q, tx_rd_q, tx_wr_d, tx_rd_d;
  logic           tx_empty_s, tx_full_s, tx_push_s, tx_pop_s;
  state_t         tx_state_q, tx_state_d;

  assign tx_empty_s = (tx_wr_q == tx_rd_q);
  assign tx_full_s  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
  assign tx_push_s  = write & ~tx_full_s;
  // Pop happens on the IDLE->START edge; CTS is only consulted in IDLE.
  assign tx_pop_s   = (tx_state_q == S_IDLE) & ~tx_empty_s & ~cts_sync_q;
  assign tx_wr_d    = tx_wr_q + (TX_AW + 1)'(tx_push_s);
  assign tx_rd_d    = tx_rd_q + (TX_AW + 1)'(tx_pop_s);

  // TX FIFO storage (no reset needed: contents are qualified by pointers).
  always_ff @(posedge CLK) begin
    if (tx_push_s) begin
      tx_mem_q[tx_wr_q[TX_AW-1:0]] <= dataIn;
    end
  end

  // ------------------------------------------------------------- TX FSM
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;

  // TX next state; the line level is computed together with the state so
  // TX is a flop that changes exactly on state boundaries.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      S_IDLE: begin
        if (tx_pop_s) begin
          tx_state_d = S_START;
          tx_cnt_d   = {CNT_W{1'b0}};
          tx_shift_d = tx_mem_q[tx_rd_q[TX_AW-1:0]];
          tx_line_d  = 1'b0;
        end else begin
          tx_line_d  = 1'b1;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = {CNT_W{1'b0}};
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = {CNT_W{1'b0}};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = {CNT_W{1'b0}};
        end else begin
          tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = {CNT_W{1'b0}};
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------- RX FSM
  state_t           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_done_s, rx_ferr_s;

  // RX next state: half-bit wait to mid-start, then sample at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_s  = 1'b0;
    rx_ferr_s  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = {CNT_W{1'b0}};
        end else begin
          rx_cnt_d   = {CNT_W{1'b0}};
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = {CNT_W{1'b0}};
          rx_bit_d = 3'd0;
          // High at mid-start means the falling edge was a glitch.
          if (rx_sync_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d   = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = {CNT_W{1'b0}};
          rx_done_s  = rx_sync_q;
          rx_ferr_s  = ~rx_sync_q;
        end else begin
          rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // ------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_PW-1:0] rx_wr_q, rx_rd_q, rx_wr_d, rx_rd_d, rx_count_d;
  logic             rx_empty_s, rx_full_s, rx_push_s, rx_pop_s, ovf_set_s;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             ovf_q, ovf_d, ferr_q, ferr_d, irq_q, irq_d, rts_n_q, rts_n_d;

  assign rx_empty_s = (rx_wr_q == rx_rd_q);
  assign rx_full_s  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
  assign rx_pop_s   = read & ~rx_empty_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push_s  = rx_done_s & (~rx_full_s | rx_pop_s);
  assign ovf_set_s  = rx_done_s & rx_full_s & ~rx_pop_s;
  assign rx_wr_d    = rx_wr_q + RX_PW'(rx_push_s);
  assign rx_rd_d    = rx_rd_q + RX_PW'(rx_pop_s);
  assign rx_count_d = rx_wr_d - rx_rd_d;

  // RX FIFO storage; on a full push+pop the write lands in the slot being read,
  // and the read returns the old head because both use pre-edge values.
  always_ff @(posedge CLK) begin
    if (rx_push_s) begin
      rx_mem_q[rx_wr_q[RX_AW-1:0]] <= rx_shift_q;
    end
  end

  // Sticky flags (set beats clear), read data and registered handshakes.
  // irq and RTS_N use next-state values so they line up with the status word.
  always_comb begin
    rx_byte_d = rx_byte_q;
    if (rx_pop_s) begin
      rx_byte_d = rx_mem_q[rx_rd_q[RX_AW-1:0]];
    end else begin
      rx_byte_d = rx_byte_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clear) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (rx_ferr_s) begin
      ferr_d = 1'b1;
    end else if (clear) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end
    irq_d   = (rx_count_d != {RX_PW{1'b0}}) | ferr_d | ovf_d;
    rts_n_d = ((RX_PW'(RX_DEPTH) - rx_count_d) <= RX_PW'(RTS_MARGIN));
  end

  // All state registers: FIFO pointers, both FSMs, flags and outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_wr_q    <= {(TX_AW + 1){1'b0}};
      tx_rd_q    <= {(TX_AW + 1){1'b0}};
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= {CNT_W{1'b0}};
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_line_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= {CNT_W{1'b0}};
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_wr_q    <= {RX_PW{1'b0}};
      rx_rd_q    <= {RX_PW{1'b0}};
      rx_byte_q  <= 8'h00;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      irq_q      <= 1'b0;
      rts_n_q    <= 1'b1;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_byte_q  <= rx_byte_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      irq_q      <= irq_d;
      rts_n_q    <= rts_n_d;
    end
  end

  assign TX      = tx_line_q;
  assign RTS_N   = rts_n_q;
  assign irq     = irq_q;
  assign dataOut = {3'b000, (tx_state_q != S_IDLE) | ~tx_empty_s, ferr_q, ovf_q,
                    rx_empty_s, tx_full_s, rx_byte_q};

endmodule
